// File: rtl/typhoon_sram_arbiter.sv
// typhoon_sram_arbiter: round-robin multi-client arbiter/controller for the async 1M x 16 SRAM.
// Define TYPHOON_BYTE_MASK_EN to add per-port byte enables driving SRAM_UB_N/SRAM_LB_N.
module typhoon_sram_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16
) (
  input  logic                          BOARD_CLK,
  input  logic                          RESET,
  input  logic [NUM_PORTS-1:0]          QueueReadReq,
  input  logic [NUM_PORTS-1:0]          QueueWriteReq,
  input  logic [NUM_PORTS*ADDR_W-1:0]   AddressToSRAM,
  input  logic [NUM_PORTS*DATA_W-1:0]   DataToSRAM,
`ifdef TYPHOON_BYTE_MASK_EN
  input  logic [NUM_PORTS*2-1:0]        ByteEnToSRAM,
`endif
  output logic [NUM_PORTS-1:0]          QueueAck,
  output logic [DATA_W-1:0]             DataFromSRAM,
  output logic [ADDR_W-1:0]             SRAM_ADDR,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_WE_N,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     port_q, port_d;
  logic                 wr_q, wr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [1:0]           ben_q, ben_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic                 ub_n_q, ub_n_d;
  logic                 lb_n_q, lb_n_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic [ADDR_W-1:0]    port_addr [NUM_PORTS];
  logic [DATA_W-1:0]    port_data [NUM_PORTS];
  logic [1:0]           port_ben  [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_valid;

  logic                 gnt_found;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     cand;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_addr[gi] = AddressToSRAM[gi*ADDR_W +: ADDR_W];
    assign port_data[gi] = DataToSRAM[gi*DATA_W +: DATA_W];
`ifdef TYPHOON_BYTE_MASK_EN
    assign port_ben[gi]  = ByteEnToSRAM[gi*2 +: 2];
`else
    assign port_ben[gi]  = 2'b11;
`endif
    // A port is ignored during its own ack cycle so a late-dropping request is not re-served.
    assign req_valid[gi] = (QueueReadReq[gi] | QueueWriteReq[gi]) & ~ack_q[gi];
  end

  // Round-robin scan: first requester at or after the pointer, wrapping upward.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    wr_d    = wr_q;
    data_d  = data_q;
    ben_d   = ben_q;
    addr_d  = addr_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    ack_d   = '0;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          state_d = ST_ACCESS;
          port_d  = gnt_idx;
          wr_d    = QueueWriteReq[gnt_idx];
          data_d  = port_data[gnt_idx];
          ben_d   = port_ben[gnt_idx];
          addr_d  = port_addr[gnt_idx];
          ce_n_d  = 1'b0;
          ub_n_d  = ~port_ben[gnt_idx][1];
          lb_n_d  = ~port_ben[gnt_idx][0];
          oe_n_d  = QueueWriteReq[gnt_idx];
          we_n_d  = ~QueueWriteReq[gnt_idx];
          dq_oe_d = QueueWriteReq[gnt_idx];
        end
      end
      ST_ACCESS: begin
        // WE_N rises here while DQ stays driven, giving the write a data-hold cycle.
        state_d = ST_FINISH;
        ce_n_d  = 1'b0;
        ub_n_d  = ~ben_q[1];
        lb_n_d  = ~ben_q[0];
        oe_n_d  = wr_q;
        dq_oe_d = wr_q;
      end
      ST_FINISH: begin
        state_d        = ST_IDLE;
        ack_d[port_q]  = 1'b1;
        ptr_d          = (port_q == PTR_W'(NUM_PORTS - 1)) ? '0 : port_q + 1'b1;
        if (!wr_q) begin
          rdata_d = SRAM_DQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      port_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ben_q   <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      ben_q   <= ben_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign SRAM_DQ      = dq_oe_q ? data_q : {DATA_W{1'bz}};
  assign SRAM_ADDR    = addr_q;
  assign SRAM_CE_N    = ce_n_q;
  assign SRAM_OE_N    = oe_n_q;
  assign SRAM_WE_N    = we_n_q;
  assign SRAM_UB_N    = ub_n_q;
  assign SRAM_LB_N    = lb_n_q;
  assign QueueAck     = ack_q;
  assign DataFromSRAM = rdata_q;

endmodule

// File: tb/tb_typhoon_sram_arbiter.sv
// Bench for typhoon_sram_arbiter: directed scenarios plus random client traffic against a
// transaction-level scheduling model; the bench SRAM decodes the low 8 address bits.
module tb_typhoon_sram_arbiter;
  localparam int NP = 4;
  localparam int AW = 20;
  localparam int DW = 16;

  logic             BOARD_CLK;
  logic             RESET;
  logic [NP-1:0]    QueueReadReq;
  logic [NP-1:0]    QueueWriteReq;
  logic [NP*AW-1:0] AddressToSRAM;
  logic [NP*DW-1:0] DataToSRAM;
`ifdef TYPHOON_BYTE_MASK_EN
  logic [NP*2-1:0]  ByteEnToSRAM;
`endif
  wire  [NP-1:0]    QueueAck;
  wire  [DW-1:0]    DataFromSRAM;
  wire  [AW-1:0]    SRAM_ADDR;
  wire  [DW-1:0]    SRAM_DQ;
  wire              SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  typhoon_sram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .BOARD_CLK     (BOARD_CLK),
    .RESET         (RESET),
    .QueueReadReq  (QueueReadReq),
    .QueueWriteReq (QueueWriteReq),
    .AddressToSRAM (AddressToSRAM),
    .DataToSRAM    (DataToSRAM),
`ifdef TYPHOON_BYTE_MASK_EN
    .ByteEnToSRAM  (ByteEnToSRAM),
`endif
    .QueueAck      (QueueAck),
    .DataFromSRAM  (DataFromSRAM),
    .SRAM_ADDR     (SRAM_ADDR),
    .SRAM_DQ       (SRAM_DQ),
    .SRAM_CE_N     (SRAM_CE_N),
    .SRAM_OE_N     (SRAM_OE_N),
    .SRAM_WE_N     (SRAM_WE_N),
    .SRAM_UB_N     (SRAM_UB_N),
    .SRAM_LB_N     (SRAM_LB_N)
  );

  initial BOARD_CLK = 1'b0;
  always #5 BOARD_CLK = ~BOARD_CLK;

  // Weak pull-ups make a released bus read back as all ones.
  for (genvar gi = 0; gi < DW; gi++) begin : g_pu
    pullup (SRAM_DQ[gi]);
  end

  // Bench SRAM: unwritten words read as {A5, addr[7:0]}, word FF preloaded with F0F0.
  logic [15:0] sram_mem [256];
  logic        sram_wr  [256];
  logic        mem_clr;
  logic [15:0] sram_rd;
  assign sram_rd = sram_wr[SRAM_ADDR[7:0]] ? sram_mem[SRAM_ADDR[7:0]] : {8'hA5, SRAM_ADDR[7:0]};
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_rd : 16'bz;

  always @(posedge BOARD_CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) sram_wr[i] <= 1'b0;
      sram_wr[255]  <= 1'b1;
      sram_mem[255] <= 16'hF0F0;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      sram_mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
      sram_wr[SRAM_ADDR[7:0]]  <= 1'b1;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: one access in flight, scheduled by grant cycle.
  bit          busy;
  int          g_cyc, g_port, ptr;
  bit          g_wr;
  logic [19:0] g_addr;
  logic [15:0] g_data, exp_rd, exp_dfs;
  logic [15:0] ref_mem [256];
  bit          rand_mode;
  int          ack_port[$];
  int          ack_at[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic set_port(input int p, input logic [19:0] a, input logic [15:0] d);
    AddressToSRAM[p*AW +: AW] = a;
    DataToSRAM[p*DW +: DW]    = d;
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] d;
    d = 16'($urandom);
    if (d == 16'hFFFF) d = 16'h7FFF;
    return d;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rst);
    bit acc, fin, ack_now, active;
    logic [NP-1:0] exp_ack, req;
    int op;
    acc     = busy && (cyc == g_cyc + 1);
    fin     = busy && (cyc == g_cyc + 2);
    ack_now = busy && (cyc == g_cyc + 3);
    active  = acc || fin;
    exp_ack = '0;
    if (ack_now) begin
      exp_ack[g_port] = 1'b1;
      if (!g_wr) exp_dfs = exp_rd;
    end
    check("ack",  32'(QueueAck), 32'(exp_ack));
    check("rdata", 32'(DataFromSRAM), 32'(exp_dfs));
    check("ce_n", 32'(SRAM_CE_N), 32'(!active));
    check("we_n", 32'(SRAM_WE_N), 32'(!(acc && g_wr)));
    check("oe_n", 32'(SRAM_OE_N), 32'(!(active && !g_wr)));
    check("ub_lb_n", 32'({SRAM_UB_N, SRAM_LB_N}), active ? 32'd0 : 32'd3);
    if (active) check("addr", 32'(SRAM_ADDR), 32'(g_addr));
    if (active && g_wr) check("dq_wr", 32'(SRAM_DQ), 32'(g_data));
    else if (!active) check("dq_rel", 32'(SRAM_DQ), 32'hFFFF);
    for (int i = 0; i < NP; i++) begin
      if (QueueAck[i]) begin
        ack_port.push_back(i);
        ack_at.push_back(cyc);
      end
    end

    if (ack_now) begin
      QueueReadReq[g_port]  = 1'b0;
      QueueWriteReq[g_port] = 1'b0;
    end
    if (rand_mode) begin
      for (int i = 0; i < NP; i++) begin
        if (QueueReadReq[i] || QueueWriteReq[i]) begin
          if ($urandom_range(0, 3) == 0) set_port(i, 20'($urandom), rand_data());
        end else if (!(ack_now && g_port == i) && $urandom_range(0, 2) == 0) begin
          op = int'($urandom_range(0, 2));
          QueueReadReq[i]  = (op != 1);
          QueueWriteReq[i] = (op != 0);
          set_port(i, 20'($urandom), rand_data());
        end
      end
    end
    RESET = rst;

    if (rst) begin
      busy    = 1'b0;
      ptr     = 0;
      exp_dfs = '0;
    end else if (!busy || ack_now) begin
      busy = 1'b0;
      req  = QueueReadReq | QueueWriteReq;
      if (ack_now) req[g_port] = 1'b0;
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (ptr + k) % NP;
        if (!busy && req[p]) begin
          busy   = 1'b1;
          g_cyc  = cyc;
          g_port = p;
          g_wr   = QueueWriteReq[p];
          g_addr = AddressToSRAM[p*AW +: AW];
          g_data = DataToSRAM[p*DW +: DW];
          if (g_wr) ref_mem[g_addr[7:0]] = g_data;
          else      exp_rd = ref_mem[g_addr[7:0]];
          ptr = (p + 1) % NP;
        end
      end
    end
    @(posedge BOARD_CLK);
    @(negedge BOARD_CLK);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic clear_log();
    ack_port.delete();
    ack_at.delete();
  endtask

  initial begin
    int t0;
    int exp_p [4];
    int exp_t [4];

    RESET         = 1'b1;
    mem_clr       = 1'b1;
    QueueReadReq  = '0;
    QueueWriteReq = '0;
    AddressToSRAM = '0;
    DataToSRAM    = '0;
`ifdef TYPHOON_BYTE_MASK_EN
    ByteEnToSRAM  = '1;
`endif
    rand_mode = 1'b0;
    busy      = 1'b0;
    ptr       = 0;
    g_cyc     = 0;
    g_port    = 0;
    g_wr      = 1'b0;
    g_addr    = '0;
    g_data    = '0;
    exp_rd    = '0;
    exp_dfs   = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = {8'hA5, 8'(i)};
    ref_mem[255] = 16'hF0F0;

    repeat (2) @(negedge BOARD_CLK);
    mem_clr = 1'b0;
    check("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
    check("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
    check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    check("rst_ub_lb_n", 32'({SRAM_UB_N, SRAM_LB_N}), 32'd3);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    check("rst_dq", 32'(SRAM_DQ), 32'hFFFF);
    check("rst_ack", 32'(QueueAck), 32'd0);
    check("rst_rdata", 32'(DataFromSRAM), 32'd0);

    // Single read of the top word.
    clear_log();
    set_port(0, 20'hFFFFF, 16'h0000);
    QueueReadReq[0] = 1'b1;
    t0 = cyc;
    run(4);
    check("rd_acks", 32'(ack_port.size()), 32'd1);
    if (ack_port.size() > 0) begin
      check("rd_port", 32'(ack_port[0]), 32'd0);
      check("rd_latency", 32'(ack_at[0] - t0), 32'd3);
    end
    check("rd_data", 32'(DataFromSRAM), 32'hF0F0);

    // Single write from port 1.
    clear_log();
    set_port(1, 20'h00010, 16'h1234);
    QueueWriteReq[1] = 1'b1;
    t0 = cyc;
    run(4);
    check("wr_acks", 32'(ack_port.size()), 32'd1);
    if (ack_port.size() > 0) begin
      check("wr_port", 32'(ack_port[0]), 32'd1);
      check("wr_latency", 32'(ack_at[0] - t0), 32'd3);
    end
    check("wr_mem", 32'(sram_mem[8'h10]), 32'h1234);

    // Round robin from pointer 0: ports 0, 2, 3, then port 0 again.
    step(1'b1);
    clear_log();
    set_port(0, 20'h00100, 16'h0);
    set_port(2, 20'h00200, 16'h0);
    set_port(3, 20'h00300, 16'h0);
    QueueReadReq = 4'b1101;
    t0 = cyc;
    for (int k = 0; k < 13; k++) begin
      if (k == 5) begin
        set_port(0, 20'h00040, 16'h0A0A);
        QueueWriteReq[0] = 1'b1;
      end
      step(1'b0);
    end
    exp_p = '{0, 2, 3, 0};
    exp_t = '{3, 6, 9, 12};
    check("rr_acks", 32'(ack_port.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_port.size(); i++) begin
      check("rr_port", 32'(ack_port[i]), 32'(exp_p[i]));
      check("rr_time", 32'(ack_at[i] - t0), 32'(exp_t[i]));
    end

    // Read and write together on port 2: a single write.
    clear_log();
    set_port(2, 20'h00022, 16'hBEEF);
    QueueReadReq[2]  = 1'b1;
    QueueWriteReq[2] = 1'b1;
    run(5);
    check("rw_acks", 32'(ack_port.size()), 32'd1);
    if (ack_port.size() > 0) check("rw_port", 32'(ack_port[0]), 32'd2);
    check("rw_mem", 32'(sram_mem[8'h22]), 32'hBEEF);

    // Reset during the ACCESS cycle of a write, then re-arbitration from pointer 0.
    clear_log();
    set_port(3, 20'h00033, 16'h5555);
    set_port(1, 20'h00010, 16'h0);
    QueueWriteReq[3] = 1'b1;
    QueueReadReq[1]  = 1'b1;
    t0 = cyc;
    step(1'b0);
    step(1'b1);
    run(8);
    exp_p = '{1, 3, 0, 0};
    exp_t = '{5, 8, 0, 0};
    check("rst_mid_acks", 32'(ack_port.size()), 32'd2);
    for (int i = 0; i < 2 && i < ack_port.size(); i++) begin
      check("rst_mid_port", 32'(ack_port[i]), 32'(exp_p[i]));
      check("rst_mid_time", 32'(ack_at[i] - t0), 32'(exp_t[i]));
    end
    check("rst_mid_rdata", 32'(DataFromSRAM), 32'h1234);

    // Random client traffic, then drain.
    rand_mode = 1'b1;
    run(3000);
    rand_mode = 1'b0;
    run(16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/typhoon_sram_arbiter.md
Name: typhoon_sram_arbiter

Overview:
- Multi-client arbiter and controller for the board's asynchronous 1M x 16 SRAM.
- Sits between the GPU's internal request queues and the external SRAM pins.
- Accepts per-client read/write requests (address plus write data) and serialises them onto the SRAM bus using round-robin arbitration.
- Returns read data and a per-client acknowledge.

Parameters:
- NUM_PORTS, 4, number of client request ports (indices 0..NUM_PORTS-1).
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.

Ports:
- BOARD_CLK  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- QueueReadReq  in  NUM_PORTS  per-port read request, level, held until ack.
- QueueWriteReq  in  NUM_PORTS  per-port write request, level, held until ack.
- AddressToSRAM  in  NUM_PORTS*ADDR_W  per-port word address; port i occupies bits [i*ADDR_W +: ADDR_W].
- DataToSRAM  in  NUM_PORTS*DATA_W  per-port write data, same packing.
- QueueAck  out  NUM_PORTS  one-cycle pulse when port i's access completes.
- DataFromSRAM  out  DATA_W  last read data, valid while QueueAck of the reading port is high.
- SRAM_ADDR  out  ADDR_W  SRAM address pins.
- SRAM_DQ  inout  DATA_W  SRAM data pins; tri-stated except during writes.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.

Behaviour:
- Reset (synchronous): state IDLE, SRAM_CE_N=SRAM_OE_N=SRAM_WE_N=1, SRAM_UB_N=SRAM_LB_N=1, SRAM_ADDR=0, SRAM_DQ=Z, QueueAck=0, DataFromSRAM=0, round-robin pointer=0.
- Reset mid-access aborts the access immediately; no ack is issued.
- States: IDLE -> ACCESS -> FINISH -> IDLE. All SRAM outputs are registered.
- IDLE:
  - A port is requesting if QueueReadReq[i] or QueueWriteReq[i] is set.
  - Grant the first requesting port at or after the pointer, scanning upward with wrap-around.
  - Latch the granted port's address, data and op. If both request bits are set on the same port, the op is a write.
  - Go to ACCESS next cycle. With no request, stay in IDLE with all controls deasserted.
- ACCESS (1 cycle):
  - SRAM_ADDR=latched address, SRAM_CE_N=0, SRAM_UB_N=SRAM_LB_N=0.
  - Read: SRAM_OE_N=0, SRAM_WE_N=1, DQ released.
  - Write: SRAM_WE_N=0, SRAM_OE_N=1, DQ driven with latched data.
- FINISH (1 cycle):
  - Address and CE held.
  - Write: WE_N returns to 1 while DQ is still driven (data hold), then DQ is released.
  - Read: OE_N stays 0 and DQ is sampled into DataFromSRAM at the end of FINISH.
- Ack and pointer update:
  - QueueAck[granted] pulses for exactly one cycle, the cycle after FINISH (back in IDLE).
  - The pointer moves to granted+1 (mod NUM_PORTS).
- Latency: request seen in IDLE cycle n -> ack in cycle n+3; 3 cycles per access.
- Back-to-back grants: a new grant may be taken in the same IDLE cycle that issues the previous ack.
- Clients must deassert their request on the ack cycle. A request still high in the cycle after its ack is treated as a new request.
- Address 20'hFFFFF (top word) is legal; there is no address wrap or masking.
- DataFromSRAM holds its value until the next read completes.
- Requests changing while not granted have no effect. Address and data are sampled only at grant.

Optional Feature:
- Macro: TYPHOON_BYTE_MASK_EN.
- When defined: adds input ByteEnToSRAM (NUM_PORTS*2 bits, bit0 = low byte, bit1 = high byte), latched at grant. During ACCESS/FINISH, SRAM_LB_N = ~en[0] and SRAM_UB_N = ~en[1].
- Reads still capture all 16 bits from DQ.
- When undefined: the port is absent, and UB_N/LB_N are both 0 during every access.

Test Plan:
- Reset: hold RESET 2 cycles -> all SRAM control outputs 1, SRAM_DQ=Z, QueueAck=0, SRAM_ADDR=0.
- Single read: port0 read, address 20'hFFFFF, SRAM model returns 16'hf0f0 -> ACCESS shows ADDR=FFFFF, CE_N=0, OE_N=0, WE_N=1; QueueAck[0] pulses 3 cycles after the request; DataFromSRAM=16'hf0f0.
- Single write: port1 write 16'h1234 to 20'h00010 -> WE_N=0 for exactly 1 cycle with DQ=1234; DQ still driven for 1 cycle after WE_N rises; model word 0x10 = 1234; QueueAck[1] pulses.
- Round robin: ports 0, 2 and 3 request simultaneously with the pointer at 0 -> serviced 0, 2, 3 in three consecutive 3-cycle accesses; a port 0 re-request is serviced after 3.
- Simultaneous read and write on port 2 -> a write is performed; exactly one ack.
- Reset asserted during ACCESS of a write -> next cycle WE_N=1, DQ=Z, no ack; pending requests are re-arbitrated from pointer 0.
